// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with per-byte write enables, a registered read
// with a valid strobe, selectable read-during-write, and an optional
// post-reset clear sweep.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping INIT_VAL into every word; requests ignored, busy=1
// S_IDLE  | accepting read/write requests when en=1
module ram_sp_clr #(
   parameter int              DW             = 8,
   parameter int              AW             = 8,
   parameter int              DEPTH          = 256,
   parameter int              RDW_MODE       = 0,
   parameter int              CLEAR_ON_RESET = 1,
   parameter logic [DW-1:0]   INIT_VAL       = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              r,
   input  logic              w,
   input  logic [AW-1:0]     addr,
   input  logic [DW-1:0]     in,
   input  logic [DW/8-1:0]   be,
   output logic [DW-1:0]     out,
   output logic              out_valid,
   output logic              busy,
   output logic              err
);

   localparam int            NB      = DW / 8;
   localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_cnt;
   logic [DW-1:0]     r_mem [0:DEPTH-1];
   logic [DW-1:0]     r_out;
   logic              r_out_valid;
   logic              r_err;

   logic              w_clearing;
   logic              w_acc;
   logic              w_in_range;
   logic [IW-1:0]     w_idx;
   logic [DW-1:0]     w_rd_old;
   logic [DW-1:0]     w_merged;
   logic              w_wr_en;
   logic [IW-1:0]     w_wr_idx;
   logic [DW-1:0]     w_wr_data;
   logic [NB-1:0]     w_wr_be;

   // Range check is done at full address width so nothing ever wraps.
   assign w_in_range = ({1'b0, addr} < DEPTH_W);
   assign w_idx      = addr[IW-1:0];
   assign w_acc      = en & (r | w) & (r_state == S_IDLE);
   assign w_rd_old   = r_mem[w_idx];

   // State register; reset restarts the sweep from scratch.
   always_ff @(posedge clk) begin
      if (rst) r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state: leave CLEAR on the edge that writes the last word.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_CLEAR && r_cnt == LAST) w_state_nxt = S_IDLE;
   end

   // Outputs derived from state.
   always_comb begin
      w_clearing = (r_state == S_CLEAR);
      busy       = w_clearing;
   end

   // Sweep address counter.
   always_ff @(posedge clk) begin
      if (rst)             r_cnt <= '0;
      else if (w_clearing) r_cnt <= r_cnt + AW'(1);
   end

   // Post-write word, used for write-first reads.
   always_comb begin
      w_merged = w_rd_old;
      for (int i = 0; i < NB; i++)
         if (be[i]) w_merged[8*i +: 8] = in[8*i +: 8];
   end

   // Single write port shared by the clear sweep and user writes.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = w_idx;
      w_wr_data = in;
      w_wr_be   = be;
      if (!rst) begin
         if (w_clearing) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_cnt[IW-1:0];
            w_wr_data = INIT_VAL;
            w_wr_be   = '1;
         end else if (w_acc && w && w_in_range) begin
            w_wr_en   = 1'b1;
         end
      end
   end

   // Memory array, byte-granular writes, never reset.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         for (int i = 0; i < NB; i++)
            if (w_wr_be[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
   end

   // Registered read data, valid and error strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         if (w_acc) begin
            if (!w_in_range) begin
               r_err <= 1'b1;
               if (r) begin
                  r_out       <= '0;
                  r_out_valid <= 1'b1;
               end
            end else if (r) begin
               r_out       <= (RDW_MODE != 0 && w) ? w_merged : w_rd_old;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign err       = r_err;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: three configurations share one request bus and are
// compared every cycle against an array-based reference model.
module tb_ram_sp_clr;

   logic        clk = 1'b0;
   logic        s_rst = 1'b1, s_en = 1'b0, s_r = 1'b0, s_w = 1'b0;
   logic [7:0]  s_addr = '0;
   logic [15:0] s_in = '0;
   logic [1:0]  s_be = '0;

   logic [7:0]  out0, out2;
   logic [15:0] out1;
   logic [2:0]  ov, bsy, er;
   logic [15:0] obs_out [3];

   int          n_chk = 0;
   int          n_err = 0;

   // configurations: 0 = defaults, 1 = 16-bit write-first with nonzero init,
   // 2 = DEPTH 200 without clear
   int          cfg_dw    [3] = '{8, 16, 8};
   int          cfg_depth [3] = '{256, 256, 200};
   int          cfg_rdw   [3] = '{0, 1, 0};
   int          cfg_clr   [3] = '{1, 1, 0};
   logic [15:0] cfg_init  [3] = '{16'h0000, 16'hA5A5, 16'h0000};

   logic [15:0] m_mem   [3][256];
   logic [1:0]  m_known [3][256];
   logic [15:0] m_out   [3];
   logic [1:0]  m_outk  [3];
   logic        m_ov    [3];
   logic        m_err   [3];
   logic        m_busy  [3];
   int          m_cnt   [3];

   always #5 clk = ~clk;

   ram_sp_clr #(.DW(8), .AW(8), .DEPTH(256), .RDW_MODE(0), .CLEAR_ON_RESET(1),
                .INIT_VAL(8'h00)) u_d0 (
      .clk(clk), .rst(s_rst), .en(s_en), .r(s_r), .w(s_w), .addr(s_addr),
      .in(s_in[7:0]), .be(s_be[0:0]), .out(out0), .out_valid(ov[0]),
      .busy(bsy[0]), .err(er[0]));

   ram_sp_clr #(.DW(16), .AW(8), .DEPTH(256), .RDW_MODE(1), .CLEAR_ON_RESET(1),
                .INIT_VAL(16'hA5A5)) u_d1 (
      .clk(clk), .rst(s_rst), .en(s_en), .r(s_r), .w(s_w), .addr(s_addr),
      .in(s_in), .be(s_be), .out(out1), .out_valid(ov[1]),
      .busy(bsy[1]), .err(er[1]));

   ram_sp_clr #(.DW(8), .AW(8), .DEPTH(200), .RDW_MODE(0), .CLEAR_ON_RESET(0),
                .INIT_VAL(8'h00)) u_d2 (
      .clk(clk), .rst(s_rst), .en(s_en), .r(s_r), .w(s_w), .addr(s_addr),
      .in(s_in[7:0]), .be(s_be[0:0]), .out(out2), .out_valid(ov[2]),
      .busy(bsy[2]), .err(er[2]));

   assign obs_out[0] = {8'h00, out0};
   assign obs_out[1] = out1;
   assign obs_out[2] = {8'h00, out2};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour for one configuration at one clock edge.
   task automatic model_step(input int k);
      logic [15:0] old, nw;
      logic [1:0]  kold, knew, bmask, b;
      int          nb;
      nb    = cfg_dw[k] / 8;
      bmask = (nb == 2) ? 2'b11 : 2'b01;
      m_ov[k]  = 1'b0;
      m_err[k] = 1'b0;
      if (s_rst) begin
         m_out[k]  = '0;
         m_outk[k] = 2'b11;
         m_busy[k] = (cfg_clr[k] != 0);
         m_cnt[k]  = 0;
      end else if (m_busy[k]) begin
         m_mem[k][m_cnt[k]]   = cfg_init[k];
         m_known[k][m_cnt[k]] = bmask;
         m_cnt[k]++;
         if (m_cnt[k] == cfg_depth[k]) m_busy[k] = 1'b0;
      end else if (s_en && (s_r || s_w)) begin
         if (int'(s_addr) >= cfg_depth[k]) begin
            m_err[k] = 1'b1;
            if (s_r) begin
               m_out[k]  = '0;
               m_outk[k] = 2'b11;
               m_ov[k]   = 1'b1;
            end
         end else begin
            old  = m_mem[k][s_addr];
            kold = m_known[k][s_addr];
            nw   = old;
            knew = kold;
            b    = s_be & bmask;
            for (int i = 0; i < nb; i++)
               if (b[i]) begin
                  nw[8*i +: 8] = s_in[8*i +: 8];
                  knew[i]      = 1'b1;
               end
            if (s_r) begin
               m_ov[k] = 1'b1;
               if (cfg_rdw[k] != 0 && s_w) begin
                  m_out[k]  = nw;
                  m_outk[k] = knew;
               end else begin
                  m_out[k]  = old;
                  m_outk[k] = kold;
               end
            end
            if (s_w) begin
               m_mem[k][s_addr]   = nw;
               m_known[k][s_addr] = knew;
            end
         end
      end
   endtask

   // Apply one request for one clock edge, then compare all instances.
   task automatic step(input logic rst_i, input logic en_i, input logic r_i,
                       input logic w_i, input logic [7:0] a_i,
                       input logic [15:0] d_i, input logic [1:0] be_i);
      logic [15:0] mask;
      s_rst = rst_i; s_en = en_i; s_r = r_i; s_w = w_i;
      s_addr = a_i; s_in = d_i; s_be = be_i;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      for (int k = 0; k < 3; k++) begin
         mask = {{8{m_outk[k][1]}}, {8{m_outk[k][0]}}};
         if (mask != 16'h0)
            chk($sformatf("d%0d.out", k), obs_out[k] & mask, m_out[k] & mask);
         chk($sformatf("d%0d.out_valid", k), ov[k], m_ov[k]);
         chk($sformatf("d%0d.busy", k), bsy[k], m_busy[k]);
         chk($sformatf("d%0d.err", k), er[k], m_err[k]);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
      step(1'b0, 1'b1, 1'b0, 1'b1, a, d, b);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b0, 1'b1, 1'b1, 1'b0, a, 16'h0000, 2'b00);
   endtask

   // Count edges until instance 0 leaves the sweep; one write is attempted
   // at address 5 while busy.
   task automatic sweep_count(output int n);
      n = 0;
      do begin
         if (n == 5) wr(8'h05, 16'hFFFF, 2'b11);
         else        idle();
         n++;
      end while (bsy[0] && n < 1000);
   endtask

   logic [7:0] hot [6] = '{8'h05, 8'h10, 8'h88, 8'hC7, 8'hC8, 8'hFF};

   initial begin
      int n;
      logic [7:0] a;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 256; j++) begin
            m_mem[k][j]   = '0;
            m_known[k][j] = 2'b00;
         end

      // reset for two cycles, then the full sweep
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 16'h1234, 2'b11);
      chk("rst_busy", bsy[0], 1'b1);
      chk("rst_out_valid", ov[0], 1'b0);
      sweep_count(n);
      chk("sweep_len", n, 256);

      rd(8'h00);
      chk("rd00", obs_out[0], 16'h0000);
      rd(8'h88);
      rd(8'hFF);
      chk("rdFF_valid", ov[0], 1'b1);
      idle();
      chk("idle_valid", ov[0], 1'b0);
      rd(8'h05);
      chk("busy_wr_ignored", obs_out[0], 16'h0000);
      chk("busy_wr_ignored_d1", obs_out[1], 16'hA5A5);

      // en=0 write is ignored
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h88, 16'hFFFF, 2'b11);
      rd(8'h88);
      chk("en0_wr", obs_out[0], 16'h0000);

      // byte enables
      wr(8'h10, 16'hABCD, 2'b11);
      wr(8'h10, 16'h1234, 2'b01);
      rd(8'h10);
      chk("be_merge_d1", obs_out[1], 16'hAB34);
      chk("be_merge_d0", obs_out[0], 16'h0034);
      idle();
      chk("be_merge_pulse", ov[1], 1'b0);

      // read-during-write
      wr(8'h88, 16'h0011, 2'b11);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h88, 16'h00FF, 2'b11);
      chk("rdw_read_first", obs_out[0], 16'h0011);
      chk("rdw_write_first", obs_out[1], 16'h00FF);
      rd(8'h88);
      chk("rdw_after", obs_out[0], 16'h00FF);

      // out of range on the DEPTH=200 instance
      wr(8'h08, 16'h003C, 2'b11);
      wr(8'hC8, 16'h0055, 2'b11);
      chk("oob_wr_err", er[2], 1'b1);
      rd(8'hC8);
      chk("oob_rd_out", obs_out[2], 16'h0000);
      chk("oob_rd_err", er[2], 1'b1);
      chk("oob_rd_valid", ov[2], 1'b1);
      rd(8'h08);
      chk("oob_no_wrap", obs_out[2], 16'h003C);
      chk("oob_no_wrap_err", er[2], 1'b0);

      // reset in mid-sweep restarts it from zero
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
      for (int i = 0; i < 100; i++) idle();
      chk("mid_sweep_busy", bsy[0], 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
      sweep_count(n);
      chk("sweep_restart_len", n, 256);
      rd(8'h88);
      chk("swept_88", obs_out[0], 16'h0000);
      rd(8'h08);
      chk("no_clear_survives", obs_out[2], 16'h003C);

      // randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         a = ($urandom_range(0, 2) == 0) ? 8'($urandom) : hot[$urandom_range(0, 5)];
         step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 7) != 0),
              1'($urandom), 1'($urandom), a, 16'($urandom), 2'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
